dense_argmax_stage: RTL
=======================

# dense_argmax_stage

Final classifier stage: consumes the pooled 16-channel vectors produced by the layer-4 conv/ReLU/maxpool controller and buffers 4 beats into a 64-entry flattened feature vector. It then runs a fully connected layer, with one MAC per cycle against an external synchronous weight memory. It reports the winning ECG class index and its score.

## Interface
- NUM_CH, 16, channels per input beat
- NUM_BEATS, 4, beats per inference; F = NUM_CH*NUM_BEATS = 64 features
- NUM_CLASSES, 5, output classes
- ACC_W, 24, signed accumulator width
- W_ADDR_W, 9, weight address width; must satisfy 2^W_ADDR_W ≥ NUM_CLASSES*(F+1)
- IDX_W, 3, class index width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; arms an inference
- valid_in  in  1  beat strobe (upstream maxflagout)
- in_data  in  8*NUM_CH  unsigned post-ReLU features; channel j at bits [8j+7:8j]
- w_en  out  1  weight memory read strobe
- w_addr  out  W_ADDR_W  weight memory address
- w_data  in  8  signed weight/bias; valid the cycle after the address
- busy  out  1  high in COLLECT and MAC
- out_valid  out  1  one-cycle result strobe
- class_idx  out  IDX_W  argmax class
- score  out  16  signed score of the winning class

## Operation
- States: IDLE, COLLECT, MAC, RESULT.
- IDLE: start → COLLECT; beat_cnt cleared. valid_in is ignored.
- COLLECT: each valid_in writes in_data into buffer row beat_cnt, then beat_cnt++. Feature k = beat*16 + j. On the NUM_BEATS-th beat → MAC.
- MAC: a linear address counter a runs from 0 to NUM_CLASSES*(F+1)−1, one per cycle, with w_en=1.
  - For class c, addresses c*(F+1)+k (k < F) hold weights; address c*(F+1)+F holds the bias.
  - Weight phase: acc += zext9(feature k) × w_data (signed 17-bit product, sign-extended to ACC_W). acc is zeroed at the start of each class.
  - Bias phase: s_c = acc + sext(w_data).
  - Argmax: if c==0 or s_c > best (strictly greater), then best ← s_c and idx ← c. Ties keep the lower index.
  - After the last bias is consumed → RESULT.
- RESULT: out_valid=1 for one cycle; class_idx=idx; score = 16-bit form of best (see Configuration) → IDLE.
- start is ignored outside IDLE. valid_in is ignored outside COLLECT.
- Arithmetic: 64 × 255 × |−128| = 2,088,960 fits in ACC_W=24. No internal saturation.

## Timing
- Reset values: busy=0, out_valid=0, class_idx=0, score=0, w_en=0, w_addr=0; state=IDLE; beat_cnt, acc and best cleared. The feature buffer is not reset.
- Edge E captures the final beat. At E, the state becomes MAC, w_addr=0 and w_en=1.
- Address a is driven after edge E+a. Its data is consumed at edge E+a+2.
- w_en deasserts after the edge that presents the last address. busy drops at edge E+326.
- out_valid, class_idx and score are registered at edge E + NUM_CLASSES*(F+1) + 1 = E+326.
- class_idx and score hold until the next out_valid or reset.
- rst mid-operation: returns immediately to reset values. No out_valid is issued, and the partial inference is discarded.

## Configuration
- DENSE_SAT_EN defined: score = best clipped to [−32768, 32767].
- DENSE_SAT_EN undefined: score = best[15:0] (wraps).
- Argmax always uses the full ACC_W value in both builds.

## Test plan
- All features 1, all weights 1, biases 0 except class 3 bias 10 → out_valid at E+326, class_idx=3, score=74.
- All weights and biases 0 → class_idx=0 (tie rule), score=0.
- Features 255; weights −128 for classes 0,1,3,4 and −127 for class 2; biases 0 → class_idx=2, best=−2,072,640. Score: 16'h5FC0 without DENSE_SAT_EN, −32768 with it.
- Assert rst 100 cycles into MAC → busy=0, w_en=0, no out_valid. A subsequent full start/4-beat sequence produces the correct result.
- Inject valid_in in IDLE, a start during MAC, and a 5th valid_in during MAC → all ignored. The buffer and result are unchanged versus the clean run.
- Beats with 10-cycle gaps versus back-to-back beats → identical result, with out_valid exactly 326 edges after the 4th beat.

Source files
------------

// File: rtl/dense_argmax_stage.sv
// Dense classifier head: buffers NUM_BEATS pooled beats, runs one MAC per cycle against a synchronous weight memory, reports argmax class and score.
// Result strobes NUM_CLASSES*(F+1)+1 edges after the last beat; no backpressure. `define DENSE_SAT_EN clips the score instead of wrapping it.
module dense_argmax_stage #(
  parameter int NUM_CH      = 16,
  parameter int NUM_BEATS   = 4,
  parameter int NUM_CLASSES = 5,
  parameter int ACC_W       = 24,
  parameter int W_ADDR_W    = 9,
  parameter int IDX_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [8*NUM_CH-1:0]   in_data,
  output logic                  w_en,
  output logic [W_ADDR_W-1:0]   w_addr,
  input  logic [7:0]            w_data,
  output logic                  busy,
  output logic                  out_valid,
  output logic [IDX_W-1:0]      class_idx,
  output logic [15:0]           score
);

  localparam int F         = NUM_CH * NUM_BEATS;
  localparam int LAST_ADDR = NUM_CLASSES * (F + 1) - 1;
  localparam int BC_W      = $clog2(NUM_BEATS + 1);
  localparam int K_W       = (F > 1) ? $clog2(F) : 1;
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-32768);

  typedef enum logic [1:0] {IDLE, COLLECT, MAC, RESULT} state_t;

  state_t                   state;
  logic [BC_W-1:0]          beat_cnt;
  logic [8*F-1:0]           feat_flat;
  logic                     rd_vld;
  logic                     in_bias;
  logic [K_W-1:0]           k;
  logic [IDX_W-1:0]         cls;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  best;
  logic [IDX_W-1:0]         best_idx;

  logic [7:0]               feat;
  logic signed [16:0]       prod;
  logic signed [ACC_W-1:0]  s_c;
  logic signed [ACC_W-1:0]  best_nxt;
  logic [IDX_W-1:0]         idx_nxt;
  logic [15:0]              score_nxt;

  always_comb begin
    feat      = feat_flat[k*8 +: 8];
    prod      = 17'($signed({1'b0, feat})) * 17'($signed(w_data));
    s_c       = acc + ACC_W'($signed(w_data));
    best_nxt  = best;
    idx_nxt   = best_idx;
    // Strict compare: a tie never displaces the lower class index.
    if (cls == '0 || s_c > best) begin
      best_nxt = s_c;
      idx_nxt  = cls;
    end
`ifdef DENSE_SAT_EN
    if (best_nxt > S_MAX)
      score_nxt = 16'h7FFF;
    else if (best_nxt < S_MIN)
      score_nxt = 16'h8000;
    else
      score_nxt = best_nxt[15:0];
`else
    score_nxt = best_nxt[15:0];
`endif
  end

  // Feature buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state == COLLECT && valid_in)
      feat_flat[beat_cnt*8*NUM_CH +: 8*NUM_CH] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      class_idx <= '0;
      score     <= '0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      rd_vld    <= 1'b0;
      in_bias   <= 1'b0;
      k         <= '0;
      cls       <= '0;
      acc       <= '0;
      best      <= '0;
      best_idx  <= '0;
    end else begin
      rd_vld <= w_en;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COLLECT;
            beat_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        COLLECT: begin
          if (valid_in) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BC_W'(NUM_BEATS - 1)) begin
              state   <= MAC;
              w_addr  <= '0;
              w_en    <= 1'b1;
              k       <= '0;
              in_bias <= 1'b0;
              cls     <= '0;
              acc     <= '0;
            end
          end
        end
        MAC: begin
          if (w_en) begin
            if (w_addr == W_ADDR_W'(LAST_ADDR))
              w_en <= 1'b0;
            else
              w_addr <= w_addr + 1'b1;
          end
          // Data returned by the memory lags its address by one cycle.
          if (rd_vld) begin
            if (!in_bias) begin
              acc <= acc + ACC_W'(prod);
              if (k == K_W'(F - 1)) begin
                k       <= '0;
                in_bias <= 1'b1;
              end else begin
                k <= k + 1'b1;
              end
            end else begin
              in_bias  <= 1'b0;
              acc      <= '0;
              best     <= best_nxt;
              best_idx <= idx_nxt;
              if (cls == IDX_W'(NUM_CLASSES - 1)) begin
                state     <= RESULT;
                busy      <= 1'b0;
                out_valid <= 1'b1;
                class_idx <= idx_nxt;
                score     <= score_nxt;
              end else begin
                cls <= cls + 1'b1;
              end
            end
          end
        end
        RESULT: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
